// File: rtl/lfsr_checker.sv
// Serial PRBS checker: self-synchronises a shadow Fibonacci LFSR to the
// incoming bit stream, then flywheels and flags every mispredicted bit.
module lfsr_checker #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
    parameter int               LOCK_CNT = 16,
    parameter int               LOSS_CNT = 4,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_err,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    // Counters are sized so LOCK_CNT-1 / LOSS_CNT-1 always fit, even when 1.
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(LOSS_CNT + 1);
    localparam logic [MW-1:0] MLAST = MW'(LOCK_CNT - 1);
    localparam logic [BW-1:0] BLAST = BW'(LOSS_CNT - 1);

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] r;
    logic [MW-1:0]   mcnt;
    logic [BW-1:0]   bcnt;
    logic            fb;
    logic            r_zero;

    // Predicted next stream bit and the all-zero guard that keeps a dead line from locking.
    always_comb begin
        fb     = ^(r & TAPS);
        r_zero = (r == '0);
    end

    // Lock/flywheel state machine with registered status, error pulse and error count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SEARCH;
            r       <= '0;
            mcnt    <= '0;
            bcnt    <= '0;
            locked  <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= 1'b0;
            if (din_valid) begin
                case (state)
                    SEARCH: begin
                        r <= {r[WIDTH-2:0], din};
                        if (r_zero || (din != fb)) begin
                            mcnt <= '0;
                        end else if (mcnt == MLAST) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            mcnt   <= '0;
                            bcnt   <= '0;
                        end else begin
                            mcnt <= mcnt + 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (din == fb) begin
                            r    <= {r[WIDTH-2:0], fb};
                            bcnt <= '0;
                        end else begin
                            err <= 1'b1;
                            if (err_cnt != '1) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                            if (bcnt == BLAST) begin
                                state  <= SEARCH;
                                locked <= 1'b0;
                                mcnt   <= '0;
                                bcnt   <= '0;
                                r      <= {r[WIDTH-2:0], din};
                            end else begin
                                bcnt <= bcnt + 1'b1;
                                r    <= {r[WIDTH-2:0], fb};
                            end
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
            // Clearing wins over an increment issued on the same edge.
            if (clr_err) begin
                err_cnt <= '0;
            end
        end
    end

endmodule
